// File: rtl/mul_rr_scheduler_pkg.sv
// Shared definitions for the round-robin multiplier scheduler: FSM state
// encoding, default widths and the pointer-width helper.
package mul_rr_scheduler_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_RUN   = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   localparam int N_DEFAULT    = 8;
   localparam int NREQ_DEFAULT = 4;

   // Width of an index into n requesters; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: returns the first set request at or after
// ptr (wrapping) as a one-hot grant plus its index. Reused by other
// shared-resource arbiters.
module rr_priority_pick #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   idx,
   output logic            any
);

   // Scan offsets from farthest to nearest so the nearest set request wins.
   always_comb begin
      int j;
      // NOTE: every output gets a default before the loop; a path that leaves
      // one unassigned would make synthesis infer a latch.
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (req[j]) begin
            grant    = '0;
            grant[j] = 1'b1;
            idx      = PW'(j);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mul_rr_scheduler.sv
// Shares one shift-and-add multiplier between NREQ requesters: round-robin
// arbitration, operand latching, LA/LB/start/done sequencing and a one-hot
// tagged response. One multiply is in flight at a time.
// Optional feature: define MUL_ARB_TIMEOUT_EN to abort a multiply that stays
// in RUN for TIMEOUT cycles (response with rsp_err = 1, rsp_data = 0).
module mul_rr_scheduler
   import mul_rr_scheduler_pkg::*;
#(
   parameter int N       = N_DEFAULT,
   parameter int NREQ    = NREQ_DEFAULT,
   parameter int TIMEOUT = 32
) (
   input  logic            Clock,
   input  logic            Resetn,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ*N-1:0] a_in,
   input  logic [NREQ*N-1:0] b_in,
   output logic [NREQ-1:0] gnt,
   output logic [NREQ-1:0] rsp_valid,
   output logic [2*N-1:0]  rsp_data,
   output logic            rsp_err,
   output logic            busy,
   output logic            mul_la,
   output logic            mul_lb,
   output logic            mul_s,
   output logic [N-1:0]    mul_da,
   output logic [N-1:0]    mul_db,
   input  logic [2*N-1:0]  mul_p,
   input  logic            mul_done
);

   localparam int PW = idx_width(NREQ);

   if (NREQ < 2 || NREQ > 8) begin : g_nreq_check
      $error("mul_rr_scheduler: NREQ must be in 2..8");
   end
   if (TIMEOUT < 1) begin : g_timeout_check
      $error("mul_rr_scheduler: TIMEOUT must be at least 1");
   end

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_next;
   logic [NREQ-1:0] win_q;
   logic [NREQ-1:0] pick_grant;
   logic [PW-1:0]   pick_idx;
   logic            pick_any;
   logic            take;
   logic            finish;
   logic            abort;

   rr_priority_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // Pointer moves just past the winner so it has lowest priority next time.
   always_comb begin
      ptr_next = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
   end

   // Multiplier controls and busy decode directly from the registered state.
   assign mul_la = (state_q == S_LOAD);
   assign mul_lb = (state_q == S_LOAD);
   assign mul_s  = (state_q == S_RUN);
   assign busy   = (state_q != S_IDLE);

`ifdef MUL_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] run_cnt_q;
   logic          err_q;

   assign abort   = (state_q == S_RUN) && !mul_done && (run_cnt_q == CW'(TIMEOUT - 1));
   assign rsp_err = err_q;

   // RUN-cycle counter, cleared in LOAD so it starts at zero on RUN entry;
   // error flag follows whichever way the last response ended.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         run_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         if (state_q == S_LOAD)     run_cnt_q <= '0;
         else if (state_q == S_RUN) run_cnt_q <= run_cnt_q + 1'b1;
         if (finish)     err_q <= 1'b0;
         else if (abort) err_q <= 1'b1;
      end
   end
`else
   assign abort   = 1'b0;
   assign rsp_err = 1'b0;
`endif

   // State register.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic and the grant/complete strobes.
   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      finish  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (pick_any) begin
               take    = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: state_d = S_RUN;
         S_RUN: begin
            if (mul_done) begin
               finish  = 1'b1;
               state_d = S_DRAIN;
            end else if (abort) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!mul_done) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Grant/response pulses, operand capture, winner tag and rr pointer.
   always_ff @(posedge Clock or negedge Resetn) begin
      // NOTE: every register here, data included, is reset so all outputs read
      // 0 while Resetn is low, matching the multiplier that shares this reset.
      if (!Resetn) begin
         gnt       <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         mul_da    <= '0;
         mul_db    <= '0;
         win_q     <= '0;
         ptr_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples
         // pre-edge values regardless of statement order.
         gnt       <= '0;
         rsp_valid <= '0;
         if (take) begin
            gnt    <= pick_grant;
            win_q  <= pick_grant;
            mul_da <= a_in[pick_idx*N +: N];
            mul_db <= b_in[pick_idx*N +: N];
            ptr_q  <= ptr_next;
         end
         if (finish) begin
            rsp_valid <= win_q;
            rsp_data  <= mul_p;
         end else if (abort) begin
            rsp_valid <= win_q;
            rsp_data  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Directed self-checking bench for mul_rr_scheduler (N=8, NREQ=4) with a
// behavioural shift-and-add multiplier attached to the mul_* ports.
// With MUL_ARB_TIMEOUT_EN defined the multiplier can be stubbed to never
// finish, exercising the abort path (TIMEOUT=4).
module tb_mul_rr_scheduler;

   localparam int N    = 8;
   localparam int NREQ = 4;

   logic            Clock;
   logic            Resetn;
   logic [NREQ-1:0] req;
   logic [NREQ*N-1:0] a_in;
   logic [NREQ*N-1:0] b_in;
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] rsp_valid;
   logic [2*N-1:0]  rsp_data;
   logic            rsp_err;
   logic            busy;
   logic            mul_la;
   logic            mul_lb;
   logic            mul_s;
   logic [N-1:0]    mul_da;
   logic [N-1:0]    mul_db;
   logic [2*N-1:0]  mul_p;
   logic            mul_done;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit overlap_seen = 1'b0;

   mul_rr_scheduler #(.N(N), .NREQ(NREQ), .TIMEOUT(4)) dut (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .mul_la    (mul_la),
      .mul_lb    (mul_lb),
      .mul_s     (mul_s),
      .mul_da    (mul_da),
      .mul_db    (mul_db),
      .mul_p     (mul_p),
      .mul_done  (mul_done)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   always @(posedge Clock) cyc <= cyc + 1;

   // gnt and rsp_valid must never be high together.
   always @(negedge Clock) begin
      if (Resetn && (|(gnt & rsp_valid))) overlap_seen <= 1'b1;
   end

   // Behavioural shift-and-add multiplier: LA/LB load operands, s starts,
   // b = 0 finishes at once, Done holds until s drops. m_stub never finishes.
   logic [N-1:0]   m_ra, m_rb, m_bsh;
   logic [2*N-1:0] m_areg, m_acc, m_nacc, m_p;
   logic           m_done;
   logic [1:0]     m_state;
   logic           m_stub = 1'b0;

   assign mul_p    = m_p;
   assign mul_done = m_done;

   always @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         m_ra <= '0; m_rb <= '0; m_bsh <= '0;
         m_areg <= '0; m_acc <= '0; m_p <= '0;
         m_done <= 1'b0; m_state <= 2'd0;
      end else begin
         if (mul_la) m_ra <= mul_da;
         if (mul_lb) m_rb <= mul_db;
         case (m_state)
            2'd0: if (mul_s) begin
               if (m_stub) m_state <= 2'd3;
               else if (m_rb == '0) begin
                  m_p <= '0; m_done <= 1'b1; m_state <= 2'd2;
               end else begin
                  m_areg <= {{N{1'b0}}, m_ra}; m_bsh <= m_rb; m_acc <= '0; m_state <= 2'd1;
               end
            end
            2'd1: begin
               m_nacc = m_acc + (m_bsh[0] ? m_areg : '0);
               m_acc  <= m_nacc;
               m_areg <= m_areg << 1;
               m_bsh  <= m_bsh >> 1;
               if (m_bsh[N-1:1] == '0) begin
                  m_p <= m_nacc; m_done <= 1'b1; m_state <= 2'd2;
               end
            end
            2'd2: if (!mul_s) begin m_done <= 1'b0; m_state <= 2'd0; end
            default: if (!mul_s) m_state <= 2'd0;
         endcase
      end
   end

   // ---------------- helpers (stimulus and waiting only) ----------------
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic set_ops(input int c, input logic [N-1:0] a, input logic [N-1:0] b);
      a_in[c*N +: N] = a;
      b_in[c*N +: N] = b;
   endtask

   task automatic apply_reset();
      req    = '0;
      Resetn = 1'b0;
      tick(); tick();
      Resetn = 1'b1;
      tick();
   endtask

   task automatic wait_gnt(output logic [NREQ-1:0] g, output int waited, output bit to);
      to = 1'b1; waited = 0; g = '0;
      for (int k = 0; k < 40; k++) begin
         tick();
         waited++;
         if (gnt != '0) begin
            g = gnt; to = 1'b0;
            break;
         end
      end
   endtask

   task automatic wait_rsp(output logic [NREQ-1:0] v, output logic [2*N-1:0] d,
                           output logic e, output int lat, output bit to);
      to = 1'b1; lat = 0; v = '0; d = '0; e = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         lat++;
         if (rsp_valid != '0) begin
            v = rsp_valid; d = rsp_data; e = rsp_err; to = 1'b0;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [44:0] obs;
      req = '0; a_in = '0; b_in = '0;
      Resetn = 1'b0;
      #2;
      tick();
      obs = {gnt, rsp_valid, rsp_data, rsp_err, busy, mul_la, mul_lb, mul_s, mul_da, mul_db};
      checks++;
      if (obs !== '0) begin
         errors++; $display("FAIL reset_outputs: got %h expected 0", obs);
      end
      Resetn = 1'b1;
      tick(); tick();
      checks++;
      if ({busy, gnt, rsp_valid} !== '0) begin
         errors++; $display("FAIL reset_idle: busy=%b gnt=%b rsp_valid=%b expected all 0", busy, gnt, rsp_valid);
      end
   endtask

   task automatic test_single();
      logic [NREQ-1:0] g, v; logic [2*N-1:0] d; logic e; int w, lat; bit to1, to2;
      set_ops(0, 8'd13, 8'd11);
      req = 4'b0001;
      wait_gnt(g, w, to1);
      req = '0;
      checks++;
      if (to1 || g !== 4'b0001 || w != 1) begin
         errors++; $display("FAIL single_gnt: got gnt=%b after %0d cycles expected 0001 after 1", g, w);
      end
      wait_rsp(v, d, e, lat, to2);
      checks++;
      if (to2 || v !== 4'b0001) begin
         errors++; $display("FAIL single_valid: got %b expected 0001", v);
      end
      checks++;
      if (d !== 16'd143) begin
         errors++; $display("FAIL single_data: got %0d expected 143", d);
      end
      checks++;
      if (e !== 1'b0) begin
         errors++; $display("FAIL single_err: got %b expected 0", e);
      end
      checks++;
      if (lat > N + 6) begin
         errors++; $display("FAIL single_latency: got %0d cycles expected at most %0d", lat, N + 6);
      end
   endtask

   task automatic test_round_robin();
      logic [NREQ-1:0] g, v; logic [2*N-1:0] d; logic e; int w, lat; bit to1, to2;
      logic [NREQ-1:0] exp_g [5];
      logic [2*N-1:0]  exp_d [5];
      int last_cyc;
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_d = '{16'd6, 16'd9, 16'd12, 16'd15, 16'd6};
      apply_reset();
      for (int i = 0; i < NREQ; i++) set_ops(i, N'(i + 2), 8'd3);
      req = 4'b1111;
      last_cyc = -100;
      for (int n = 0; n < 5; n++) begin
         wait_gnt(g, w, to1);
         checks++;
         if (to1 || g !== exp_g[n]) begin
            errors++; $display("FAIL rr_gnt%0d: got %b expected %b", n, g, exp_g[n]);
         end
         if (n > 0) begin
            checks++;
            if (cyc - last_cyc < 5) begin
               errors++; $display("FAIL rr_spacing%0d: got %0d cycles expected at least 5", n, cyc - last_cyc);
            end
         end
         last_cyc = cyc;
         wait_rsp(v, d, e, lat, to2);
         checks++;
         if (to2 || v !== exp_g[n] || d !== exp_d[n]) begin
            errors++; $display("FAIL rr_rsp%0d: got valid=%b data=%0d expected valid=%b data=%0d", n, v, d, exp_g[n], exp_d[n]);
         end
      end
      req = '0;
      tick(); tick(); tick();
   endtask

   task automatic test_boundaries();
      logic [NREQ-1:0] g, v; logic [2*N-1:0] d; logic e; int w, lat; bit to1, to2;
      int             cl [3];
      logic [N-1:0]   av [3];
      logic [N-1:0]   bv [3];
      logic [2*N-1:0] pv [3];
      cl = '{1, 2, 3};
      av = '{8'd200, 8'd0, 8'd255};
      bv = '{8'd0, 8'd255, 8'd255};
      pv = '{16'd0, 16'd0, 16'd65025};
      for (int n = 0; n < 3; n++) begin
         set_ops(cl[n], av[n], bv[n]);
         req = '0; req[cl[n]] = 1'b1;
         wait_gnt(g, w, to1);
         req = '0;
         wait_rsp(v, d, e, lat, to2);
         checks++;
         if (to1 || to2 || d !== pv[n] || e !== 1'b0 || lat > N + 6) begin
            errors++;
            $display("FAIL bound%0d: got data=%0d err=%b lat=%0d expected data=%0d err=0 lat<=%0d",
                     n, d, e, lat, pv[n], N + 6);
         end
      end
      tick(); tick(); tick();
   endtask

   task automatic test_reset_mid_run();
      logic [NREQ-1:0] g, v; logic [2*N-1:0] d; logic e; int w, lat; bit to1, to2;
      logic [44:0] obs;
      bit spurious;
      set_ops(0, 8'd7, 8'd9);
      req = 4'b0001;
      wait_gnt(g, w, to1);
      req = '0;
      tick(); tick(); tick();
      checks++;
      if (to1 || mul_s !== 1'b1) begin
         errors++; $display("FAIL midrun_in_run: got mul_s=%b expected 1", mul_s);
      end
      #3;
      Resetn = 1'b0;
      #1;
      obs = {gnt, rsp_valid, rsp_data, rsp_err, busy, mul_la, mul_lb, mul_s, mul_da, mul_db};
      checks++;
      if (obs !== '0) begin
         errors++; $display("FAIL midrun_async_clear: got %h expected 0", obs);
      end
      tick(); tick();
      Resetn = 1'b1;
      spurious = 1'b0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (rsp_valid != '0) spurious = 1'b1;
      end
      checks++;
      if (spurious) begin
         errors++; $display("FAIL midrun_no_rsp: got a response expected none");
      end
      set_ops(2, 8'd7, 8'd9);
      req = 4'b0100;
      wait_gnt(g, w, to1);
      req = '0;
      wait_rsp(v, d, e, lat, to2);
      checks++;
      if (to1 || to2 || g !== 4'b0100 || v !== 4'b0100 || d !== 16'd63) begin
         errors++; $display("FAIL midrun_after: got gnt=%b valid=%b data=%0d expected 0100 0100 63", g, v, d);
      end
      tick(); tick(); tick();
   endtask

   task automatic test_back_to_back();
      logic [NREQ-1:0] g, v; logic [2*N-1:0] d, d0; logic e; int w, lat; bit to1, to2;
      bit seen_rsp0, prev_busy, got;
      set_ops(0, 8'd5, 8'd6);
      set_ops(2, 8'd10, 8'd10);
      req = 4'b0001;
      wait_gnt(g, w, to1);
      req = '0;
      checks++;
      if (to1 || g !== 4'b0001) begin
         errors++; $display("FAIL b2b_gnt0: got %b expected 0001", g);
      end
      tick(); tick();
      req = 4'b0100;
      seen_rsp0 = 1'b0; prev_busy = 1'b1; got = 1'b0; d0 = '0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (rsp_valid == 4'b0001) begin seen_rsp0 = 1'b1; d0 = rsp_data; end
         if (gnt != '0) begin got = 1'b1; break; end
         prev_busy = busy;
      end
      req = '0;
      checks++;
      if (!got || gnt !== 4'b0100) begin
         errors++; $display("FAIL b2b_gnt2: got %b expected 0100", gnt);
      end
      checks++;
      if (!seen_rsp0 || d0 !== 16'd30) begin
         errors++; $display("FAIL b2b_rsp0: got seen=%b data=%0d expected 1 30", seen_rsp0, d0);
      end
      checks++;
      if (prev_busy !== 1'b0) begin
         errors++; $display("FAIL b2b_after_drain: got busy=%b before gnt expected 0", prev_busy);
      end
      wait_rsp(v, d, e, lat, to2);
      checks++;
      if (to2 || v !== 4'b0100 || d !== 16'd100) begin
         errors++; $display("FAIL b2b_rsp2: got valid=%b data=%0d expected 0100 100", v, d);
      end
      checks++;
      if (overlap_seen) begin
         errors++; $display("FAIL b2b_overlap: got gnt and rsp_valid together expected never");
      end
      tick(); tick(); tick();
   endtask

`ifdef MUL_ARB_TIMEOUT_EN
   task automatic test_timeout();
      logic [NREQ-1:0] g, v; logic [2*N-1:0] d; logic e; int w, lat; bit to1, to2;
      m_stub = 1'b1;
      set_ops(1, 8'd3, 8'd3);
      req = 4'b0010;
      wait_gnt(g, w, to1);
      req = '0;
      wait_rsp(v, d, e, lat, to2);
      checks++;
      if (to1 || to2 || v !== 4'b0010 || e !== 1'b1 || d !== 16'd0) begin
         errors++; $display("FAIL timeout_rsp: got valid=%b err=%b data=%0d expected 0010 1 0", v, e, d);
      end
      checks++;
      if (lat != 5) begin
         errors++; $display("FAIL timeout_latency: got %0d cycles after gnt expected 5", lat);
      end
      tick(); tick(); tick();
      m_stub = 1'b0;
      set_ops(1, 8'd4, 8'd5);
      req = 4'b0010;
      wait_gnt(g, w, to1);
      req = '0;
      wait_rsp(v, d, e, lat, to2);
      checks++;
      if (to1 || to2 || e !== 1'b0 || d !== 16'd20) begin
         errors++; $display("FAIL timeout_recover: got err=%b data=%0d expected 0 20", e, d);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_boundaries();
      test_reset_mid_run();
      test_back_to_back();
`ifdef MUL_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
